// File: rtl/pc_gen_unit.sv
// pc_gen_unit: fetch-stage PC register and next-PC selection.
// Handles sequential flow, branch, J-type, register jump, eret and
// exception entry. Redirects that arrive while stalled are held in a
// one-entry pending buffer. Optional return-address stack: PC_RAS_EN.
// Ports:
//   clk, reset (async, active-high), stall, npc_op[2:0]
//   br_pc, imm16, imm26, reg_target, epc, exc_req, link, is_ret
//   pc, pc4, pc_adel, ras_top, ras_valid
module pc_gen_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = 'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VEC   = 'h0000_4180,
  parameter logic [WIDTH-1:0] IMEM_LAST = 'h0000_6FFC,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       npc_op,
  input  logic [WIDTH-1:0] br_pc,
  input  logic [15:0]      imm16,
  input  logic [25:0]      imm26,
  input  logic [WIDTH-1:0] reg_target,
  input  logic [WIDTH-1:0] epc,
  input  logic             exc_req,
  input  logic             link,
  input  logic             is_ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc4,
  output logic             pc_adel,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_valid
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic             pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0] bp4;
  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] tgt;
  logic             redir;

  assign bp4    = br_pc + WIDTH'(4);
  assign br_off = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};

  always_comb begin
    tgt   = '0;
    redir = 1'b1;
    unique case (npc_op)
      3'b001:  tgt = bp4 + br_off;
      3'b010:  tgt = {bp4[WIDTH-1:28], imm26, 2'b00};
      3'b011:  tgt = reg_target;
      3'b100:  tgt = epc;
      default: redir = 1'b0;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    if (exc_req) begin
      pc_d       = EXC_VEC;
      pend_vld_d = 1'b0;
    end else if (!stall) begin
      pend_vld_d = 1'b0;
      if (redir)
        pc_d = tgt;
      else if (pend_vld_q)
        pc_d = pend_tgt_q;
      else
        pc_d = pc_q + WIDTH'(4);
    end else if (redir) begin
      // newest redirect wins while frozen
      pend_tgt_d = tgt;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc      = pc_q;
  assign pc4     = pc_q + WIDTH'(4);
  assign pc_adel = (pc_q[1:0] != 2'b00) | (pc_q < RESET_PC)
                 | (pc_q > IMEM_LAST);

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] stk_q [RAS_DEPTH];
  logic [PW-1:0]    ptr_q;
  logic [PW:0]      cnt_q;
  logic [PW-1:0]    top_idx;
  logic [WIDTH-1:0] ra;
  logic             upd;

  // ptr_q is the next free slot; wrapping overwrites the oldest entry
  assign top_idx = ptr_q - PW'(1);
  assign ra      = br_pc + WIDTH'(8);
  assign upd     = !stall && !exc_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++)
        stk_q[i] <= '0;
    end else if (upd) begin
      if (link && is_ret && cnt_q != '0) begin
        stk_q[top_idx] <= ra;
      end else if (link) begin
        stk_q[ptr_q] <= ra;
        ptr_q        <= ptr_q + PW'(1);
        if (cnt_q != FULL)
          cnt_q <= cnt_q + (PW+1)'(1);
      end else if (is_ret && cnt_q != '0) begin
        ptr_q <= top_idx;
        cnt_q <= cnt_q - (PW+1)'(1);
      end
    end
  end

  assign ras_top   = stk_q[top_idx];
  assign ras_valid = (cnt_q != '0);
`else
  logic unused_ras;
  assign unused_ras = ^{link, is_ret};
  assign ras_top    = '0;
  assign ras_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb_pc_gen_unit: directed plus randomized checks of pc_gen_unit
// against a behavioural next-PC / return-stack model.
module tb_pc_gen_unit;

  localparam logic [31:0] RST = 32'h0000_3000;
  localparam logic [31:0] EXC = 32'h0000_4180;
  localparam logic [31:0] LST = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  npc_op;
  logic [31:0] br_pc;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] reg_target;
  logic [31:0] epc;
  logic        exc_req;
  logic        link;
  logic        is_ret;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        pc_adel;
  logic [31:0] ras_top;
  logic        ras_valid;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pc;
  logic [31:0] m_pt;
  bit          m_pv;
  logic [31:0] m_ras [$];

  pc_gen_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op),
    .br_pc(br_pc), .imm16(imm16), .imm26(imm26),
    .reg_target(reg_target), .epc(epc), .exc_req(exc_req),
    .link(link), .is_ret(is_ret), .pc(pc), .pc4(pc4),
    .pc_adel(pc_adel), .ras_top(ras_top), .ras_valid(ras_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_target();
    int off;
    off = int'($signed(imm16)) * 4;
    case (npc_op)
      3'd1: return br_pc + 32'd4 + 32'(off);
      3'd2: return ((br_pc + 32'd4) & 32'hF000_0000)
                   | (32'(imm26) * 32'd4);
      3'd3: return reg_target;
      default: return epc;
    endcase
  endfunction

  function automatic bit m_adel(logic [31:0] p);
    return (p % 4 != 0) || (p < RST) || (p > LST);
  endfunction

  task automatic model_edge();
    bit rd;
    rd = (npc_op >= 3'd1) && (npc_op <= 3'd4);
    if (exc_req) begin
      m_pc = EXC;
      m_pv = 0;
    end else if (!stall) begin
      if (rd) m_pc = m_target();
      else if (m_pv) m_pc = m_pt;
      else m_pc = m_pc + 32'd4;
      m_pv = 0;
`ifdef PC_RAS_EN
      if (is_ret && m_ras.size() > 0) void'(m_ras.pop_back());
      if (link) begin
        m_ras.push_back(br_pc + 32'd8);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
`endif
    end else if (rd) begin
      m_pt = m_target();
      m_pv = 1;
    end
  endtask

  task automatic compare();
    chk("pc", pc, m_pc);
    chk("pc4", pc4, m_pc + 32'd4);
    chk("pc_adel", {31'b0, pc_adel}, {31'b0, m_adel(m_pc)});
    chk("ras_valid", {31'b0, ras_valid}, {31'b0, m_ras.size() != 0});
    if (m_ras.size() != 0)
      chk("ras_top", ras_top, m_ras[m_ras.size()-1]);
`ifndef PC_RAS_EN
    chk("ras_top0", ras_top, 32'h0);
`endif
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    reset = 1; stall = 0; npc_op = 0; br_pc = 0; imm16 = 0;
    imm26 = 0; reg_target = 0; epc = 0; exc_req = 0;
    link = 0; is_ret = 0;
    m_pc = RST; m_pv = 0; m_pt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, RST);
    chk("rst_pc4", pc4, RST + 32'd4);
    chk("rst_adel", {31'b0, pc_adel}, 32'd0);
    chk("rst_rasv", {31'b0, ras_valid}, 32'd0);
    reset = 0;

    tick(); chk("seq1", pc, 32'h3004);
    tick(); chk("seq2", pc, 32'h3008);
    tick(); chk("seq3", pc, 32'h300C);

    br_pc = 32'h3010; imm16 = 16'hFFFC; npc_op = 3'd1;
    tick(); chk("br_back", pc, 32'h3004);
    imm16 = 16'h0003;
    tick(); chk("br_fwd", pc, 32'h3020);

    stall = 1; npc_op = 3'd3; reg_target = 32'h3100;
    tick(); chk("stall_hold1", pc, 32'h3020);
    tick(); chk("stall_hold2", pc, 32'h3020);
    stall = 0; npc_op = 3'd0;
    tick(); chk("pend_take", pc, 32'h3100);
    tick(); chk("pend_seq", pc, 32'h3104);

    stall = 1; npc_op = 3'd2; imm26 = 26'h0000_123; exc_req = 1;
    tick(); chk("exc", pc, EXC);
    stall = 0; npc_op = 3'd0; exc_req = 0;
    tick(); chk("exc_nopend", pc, EXC + 32'd4);
    npc_op = 3'd4; epc = 32'h3044;
    tick(); chk("eret", pc, 32'h3044);

    npc_op = 3'd3; reg_target = 32'h3002;
    tick(); chk("adel_mis", {31'b0, pc_adel}, 32'd1);
    reg_target = 32'h7000;
    tick(); chk("adel_hi", {31'b0, pc_adel}, 32'd1);
    reg_target = 32'h6FFC;
    tick(); chk("adel_last", {31'b0, pc_adel}, 32'd0);
    reg_target = 32'hFFFF_FFFC;
    tick();
    npc_op = 3'd0;
    tick(); chk("wrap", pc, 32'h0);
    chk("wrap_adel", {31'b0, pc_adel}, 32'd1);

    link = 1;
    for (int i = 0; i < 5; i++) begin
      br_pc = 32'h3000 + 32'(i) * 32'd4;
      tick();
    end
    link = 0;
`ifdef PC_RAS_EN
    chk("ras_top5", ras_top, 32'h3018);
    chk("ras_v5", {31'b0, ras_valid}, 32'd1);
`endif
    is_ret = 1;
    repeat (4) tick();
    chk("ras_empty", {31'b0, ras_valid}, 32'd0);
    tick();
    chk("ras_pop_empty", {31'b0, ras_valid}, 32'd0);
    is_ret = 0;

    for (int n = 0; n < 400; n++) begin
      stall      = ($urandom_range(0, 9) < 3);
      exc_req    = ($urandom_range(0, 19) == 0);
      npc_op     = 3'($urandom_range(0, 7));
      br_pc      = 32'h3000 + (32'($urandom_range(0, 4095)) << 2);
      imm16      = 16'($urandom);
      imm26      = 26'($urandom);
      reg_target = ($urandom_range(0, 3) == 0) ? $urandom
                 : 32'h3000 + (32'($urandom_range(0, 4095)) << 2);
      epc        = 32'h3000 + 32'($urandom_range(0, 16383));
      link       = ($urandom_range(0, 3) == 0);
      is_ret     = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
